// File: rtl/spi_mult_ctrl_pkg.sv
// Shared constants for the SPI multiplier controller: shift-register modes,
// command opcodes, tx parallel-in mux selects and FSM state encoding.
package spi_mult_ctrl_pkg;

  localparam int DATA_W_DEF = 8;

  localparam logic [1:0] MODE_HOLD  = 2'b00;
  localparam logic [1:0] MODE_RIGHT = 2'b01;
  localparam logic [1:0] MODE_LEFT  = 2'b10;
  localparam logic [1:0] MODE_PLOAD = 2'b11;

  localparam logic [7:0] OP_WR_A      = 8'h01;
  localparam logic [7:0] OP_WR_B      = 8'h02;
  localparam logic [7:0] OP_START     = 8'h03;
  localparam logic [7:0] OP_RD_RESULT = 8'h04;
  localparam logic [7:0] OP_RD_STATUS = 8'h05;

  localparam logic [1:0] TXSEL_HI     = 2'b00;
  localparam logic [1:0] TXSEL_LO     = 2'b01;
  localparam logic [1:0] TXSEL_STATUS = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_GET_CMD  = 3'd1,
    ST_DECODE   = 3'd2,
    ST_GET_DATA = 3'd3,
    ST_STORE    = 3'd4,
    ST_LOAD_OUT = 3'd5,
    ST_SEND     = 3'd6,
    ST_IGNORE   = 3'd7
  } state_e;

  function automatic logic op_is_write(input logic [7:0] op);
    return (op == OP_WR_A) || (op == OP_WR_B);
  endfunction

endpackage

// File: rtl/spi_bit_counter.sv
// Bit counter shared by the rx and tx paths; o_tc flags the last bit of a byte.
module spi_bit_counter #(
  parameter int CNT_W = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  logic [CNT_W-1:0] r_count;

  // Counter: clear has priority, wraps to zero after the last bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      r_count <= r_count;
    end
  end

  assign o_tc = (r_count == {CNT_W{1'b1}});

endmodule

// File: rtl/spi_mult_ctrl.sv
// SPI transaction controller: decodes the command byte, steers the rx/tx shift
// registers, strobes operand loads / multiply start and tracks result_valid.
module spi_mult_ctrl
  import spi_mult_ctrl_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cs_n,
  input  logic              sclk_posedge,
  input  logic              sclk_negedge,
  input  logic [DATA_W-1:0] rx_byte,
  input  logic              mult_done,
  output logic [1:0]        rx_mode,
  output logic              rx_shift_en,
  output logic [1:0]        tx_mode,
  output logic              tx_shift_en,
  output logic [1:0]        tx_sel,
  output logic              load_a,
  output logic              load_b,
  output logic              mult_start,
  output logic              result_valid,
  output logic              miso_oe
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [DATA_W-1:0] C_WR_A      = DATA_W'(OP_WR_A);
  localparam logic [DATA_W-1:0] C_WR_B      = DATA_W'(OP_WR_B);
  localparam logic [DATA_W-1:0] C_START     = DATA_W'(OP_START);
  localparam logic [DATA_W-1:0] C_RD_RESULT = DATA_W'(OP_RD_RESULT);
  localparam logic [DATA_W-1:0] C_RD_STATUS = DATA_W'(OP_RD_STATUS);

  state_e            r_state;
  state_e            w_next;
  logic [DATA_W-1:0] r_op;
  logic [1:0]        r_tx_sel;
  logic              r_skip_neg;
  logic              r_result_valid;
  logic              w_cnt_clr;
  logic              w_cnt_en;
  logic              w_cnt_tc;
  logic              w_mult_start;

  spi_bit_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .i_clr (w_cnt_clr),
    .i_en  (w_cnt_en),
    .o_tc  (w_cnt_tc)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Latched opcode, tx byte select, and the skip flag for the trailing SCLK fall of the previous byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op       <= '0;
      r_tx_sel   <= TXSEL_HI;
      r_skip_neg <= 1'b0;
    end else if (cs_n) begin
      r_op       <= '0;
      r_tx_sel   <= TXSEL_HI;
      r_skip_neg <= 1'b0;
    end else begin
      if (r_state == ST_DECODE) begin
        r_op     <= rx_byte;
        r_tx_sel <= (rx_byte == C_RD_STATUS) ? TXSEL_STATUS : TXSEL_HI;
      end else if ((r_state == ST_SEND) && (w_next == ST_LOAD_OUT)) begin
        r_op     <= r_op;
        r_tx_sel <= TXSEL_LO;
      end else begin
        r_op     <= r_op;
        r_tx_sel <= r_tx_sel;
      end
      if (r_state == ST_LOAD_OUT) begin
        r_skip_neg <= 1'b1;
      end else if ((r_state == ST_SEND) && sclk_negedge) begin
        r_skip_neg <= 1'b0;
      end else begin
        r_skip_neg <= r_skip_neg;
      end
    end
  end

  // result_valid: a new start outranks a coincident done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result_valid <= 1'b0;
    end else if (w_mult_start) begin
      r_result_valid <= 1'b0;
    end else if (mult_done) begin
      r_result_valid <= 1'b1;
    end else begin
      r_result_valid <= r_result_valid;
    end
  end

  // Next-state and output decode; chip select high overrides everything.
  always_comb begin
    w_next       = r_state;
    rx_mode      = MODE_HOLD;
    rx_shift_en  = 1'b0;
    tx_mode      = MODE_HOLD;
    tx_shift_en  = 1'b0;
    load_a       = 1'b0;
    load_b       = 1'b0;
    w_mult_start = 1'b0;
    miso_oe      = 1'b0;
    w_cnt_clr    = 1'b1;
    w_cnt_en     = 1'b0;
    if (cs_n) begin
      w_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: w_next = ST_GET_CMD;
        ST_GET_CMD, ST_GET_DATA: begin
          rx_mode     = MODE_LEFT;
          rx_shift_en = sclk_posedge;
          w_cnt_clr   = 1'b0;
          w_cnt_en    = sclk_posedge;
          if (sclk_posedge && w_cnt_tc) begin
            w_next = (r_state == ST_GET_CMD) ? ST_DECODE : ST_STORE;
          end else begin
            w_next = r_state;
          end
        end
        ST_DECODE: begin
          if ((rx_byte == C_WR_A) || (rx_byte == C_WR_B)) begin
            w_next = ST_GET_DATA;
          end else if (rx_byte == C_START) begin
            w_mult_start = 1'b1;
            w_next       = ST_IGNORE;
          end else if ((rx_byte == C_RD_RESULT) || (rx_byte == C_RD_STATUS)) begin
            w_next = ST_LOAD_OUT;
          end else begin
            w_next = ST_IGNORE;
          end
        end
        ST_STORE: begin
          load_a = (r_op == C_WR_A);
          load_b = (r_op == C_WR_B);
          w_next = ST_IGNORE;
        end
        ST_LOAD_OUT: begin
          tx_mode     = MODE_PLOAD;
          tx_shift_en = 1'b1;
          miso_oe     = 1'b1;
          w_next      = ST_SEND;
        end
        ST_SEND: begin
          miso_oe     = 1'b1;
          tx_mode     = MODE_LEFT;
          tx_shift_en = sclk_negedge && !r_skip_neg;
          w_cnt_clr   = 1'b0;
          w_cnt_en    = sclk_posedge;
          if (sclk_posedge && w_cnt_tc) begin
            if ((r_op == C_RD_RESULT) && (r_tx_sel == TXSEL_HI)) begin
              w_next = ST_LOAD_OUT;
            end else begin
              w_next = ST_IGNORE;
            end
          end else begin
            w_next = ST_SEND;
          end
        end
        ST_IGNORE: w_next = ST_IGNORE;
        default:   w_next = ST_IDLE;
      endcase
    end
  end

  assign mult_start   = w_mult_start;
  assign result_valid = r_result_valid;
  assign tx_sel       = r_tx_sel;

endmodule

// File: tb/tb_spi_mult_ctrl.sv
// Scoreboard bench for spi_mult_ctrl with behavioural shift registers and multiplier around it.
module tb_spi_mult_ctrl;
  import spi_mult_ctrl_pkg::*;

  localparam logic [1:0] K_LOAD_A = 2'd0;
  localparam logic [1:0] K_LOAD_B = 2'd1;
  localparam logic [1:0] K_START  = 2'd2;
  localparam logic [1:0] K_MISO   = 2'd3;

  typedef struct packed {
    logic [1:0] kind;
    logic [7:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cs_n = 1'b1;
  logic sclk_posedge = 1'b0;
  logic sclk_negedge = 1'b0;
  logic mult_done;
  logic [7:0] rx_byte;
  logic [1:0] rx_mode, tx_mode, tx_sel;
  logic rx_shift_en, tx_shift_en, load_a, load_b, mult_start, result_valid, miso_oe;

  logic        mosi = 1'b0;
  logic [7:0]  m_rx = 8'h00;
  logic [7:0]  m_tx = 8'h00;
  logic [7:0]  m_a = 8'h00;
  logic [7:0]  m_b = 8'h00;
  logic [15:0] m_res = 16'h0000;
  int          m_cnt = 0;
  logic        same_clk_mode = 1'b0;
  logic [7:0]  tx_pin;
  logic        miso;
  logic [12:0] all_outs;

  exp_t exp_q[$];
  int total = 0;
  int bad = 0;
  int pload_cnt = 0;
  int oe_cnt = 0;
  int strobe_cnt = 0;
  int bad_shift = 0;
  int mon_bits = 0;
  logic [7:0] mon_sh = 8'h00;

  spi_mult_ctrl dut (
    .clk(clk), .rst_n(rst_n), .cs_n(cs_n),
    .sclk_posedge(sclk_posedge), .sclk_negedge(sclk_negedge),
    .rx_byte(rx_byte), .mult_done(mult_done),
    .rx_mode(rx_mode), .rx_shift_en(rx_shift_en),
    .tx_mode(tx_mode), .tx_shift_en(tx_shift_en), .tx_sel(tx_sel),
    .load_a(load_a), .load_b(load_b), .mult_start(mult_start),
    .result_valid(result_valid), .miso_oe(miso_oe)
  );

  always #5 clk = ~clk;

  assign rx_byte   = m_rx;
  assign miso      = m_tx[7];
  assign mult_done = (m_cnt == 1) || (same_clk_mode && mult_start);
  assign all_outs  = {rx_mode, rx_shift_en, tx_mode, tx_shift_en, tx_sel,
                      load_a, load_b, mult_start, result_valid, miso_oe};

  always_comb begin
    case (tx_sel)
      2'b00:   tx_pin = m_res[15:8];
      2'b01:   tx_pin = m_res[7:0];
      default: tx_pin = {7'b0000000, result_valid};
    endcase
  end

  // External shift registers and a multiplier that answers 5 clk after start.
  always @(posedge clk) begin
    if (rx_shift_en && rx_mode == MODE_LEFT) m_rx <= {m_rx[6:0], mosi};
    if (tx_shift_en && tx_mode == MODE_PLOAD) m_tx <= tx_pin;
    else if (tx_shift_en && tx_mode == MODE_LEFT) m_tx <= {m_tx[6:0], 1'b0};
    if (load_a) m_a <= m_rx;
    if (load_b) m_b <= m_rx;
    if (mult_start && !same_clk_mode) m_cnt <= 5;
    else if (m_cnt != 0) m_cnt <= m_cnt - 1;
    if (m_cnt == 1) m_res <= 16'(m_a) * 16'(m_b);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  task automatic mon_event(input logic [1:0] k, input logic [7:0] d, input string name);
    exp_t e;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL unexpected_%s: got 0x%0h expected none", name, d);
    end else begin
      e = exp_q.pop_front();
      check(name, {22'd0, k, d}, {22'd0, e.kind, e.data});
    end
  endtask

  // Monitor: pops the scoreboard on every strobe and every completed MISO byte.
  always @(negedge clk) begin
    if (rst_n) begin
      if (load_a) mon_event(K_LOAD_A, rx_byte, "load_a");
      if (load_b) mon_event(K_LOAD_B, rx_byte, "load_b");
      if (mult_start) mon_event(K_START, 8'h00, "mult_start");
      strobe_cnt += int'(load_a) + int'(load_b) + int'(mult_start);
      if (tx_mode == MODE_PLOAD) pload_cnt++;
      if (miso_oe) oe_cnt++;
      if (tx_shift_en && tx_mode == MODE_LEFT && !sclk_negedge) bad_shift++;
      if (cs_n) begin
        mon_bits = 0;
      end else if (sclk_posedge && miso_oe) begin
        mon_sh = {mon_sh[6:0], miso};
        mon_bits++;
        if (mon_bits == 8) begin
          mon_event(K_MISO, mon_sh, "miso_byte");
          mon_bits = 0;
        end
      end
    end
  end

  task automatic clk_wait(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic spi_bits(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      mosi = b[7-i];
      clk_wait(5);
      sclk_posedge = 1'b1;
      clk_wait(1);
      sclk_posedge = 1'b0;
      clk_wait(5);
      sclk_negedge = 1'b1;
      clk_wait(1);
      sclk_negedge = 1'b0;
    end
  endtask

  task automatic frame(input int n, input logic [23:0] b);
    cs_n = 1'b0;
    clk_wait(4);
    for (int i = 0; i < n; i++) spi_bits(b[23-8*i -: 8], 8);
    clk_wait(4);
    cs_n = 1'b1;
    clk_wait(4);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int snap_a, snap_b, snap_c;
    clk_wait(3);
    check("reset_outs", 32'(all_outs), 32'h0);
    rst_n = 1'b1;
    clk_wait(2);

    // Async reset in the middle of a command byte
    cs_n = 1'b0;
    clk_wait(4);
    spi_bits(8'h01, 3);
    check("get_cmd_rx_mode", 32'(rx_mode), 32'(MODE_LEFT));
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_outs", 32'(all_outs), 32'h0);
    check("async_reset_state", 32'(dut.r_state), 32'(ST_IDLE));
    check("async_reset_cnt", 32'(dut.u_cnt.r_count), 32'h0);
    clk_wait(2);
    cs_n = 1'b1;
    rst_n = 1'b1;
    clk_wait(4);

    // Operand writes
    exp_q.push_back('{kind: K_LOAD_A, data: 8'h0C});
    frame(2, 24'h010C00);
    exp_q.push_back('{kind: K_LOAD_B, data: 8'h0D});
    frame(2, 24'h020D00);

    // Start, then status read
    check("rv_before_start", 32'(result_valid), 32'h0);
    exp_q.push_back('{kind: K_START, data: 8'h00});
    frame(1, 24'h030000);
    clk_wait(4);
    check("rv_after_done", 32'(result_valid), 32'h1);
    exp_q.push_back('{kind: K_MISO, data: 8'h01});
    frame(2, 24'h050000);

    // Two-byte result read, MSB first
    snap_a = pload_cnt;
    exp_q.push_back('{kind: K_MISO, data: 8'h00});
    exp_q.push_back('{kind: K_MISO, data: 8'h9C});
    frame(3, 24'h040000);
    check("pload_count", 32'(pload_cnt - snap_a), 32'd2);

    // Data byte aborted after 4 bits, then a normal write
    snap_a = strobe_cnt;
    cs_n = 1'b0;
    clk_wait(4);
    spi_bits(8'h01, 8);
    spi_bits(8'hAA, 4);
    clk_wait(2);
    cs_n = 1'b1;
    clk_wait(4);
    check("abort_no_load", 32'(strobe_cnt - snap_a), 32'd0);
    exp_q.push_back('{kind: K_LOAD_A, data: 8'h0C});
    frame(2, 24'h010C00);

    // Unknown opcode with trailing bytes
    snap_b = oe_cnt;
    snap_c = strobe_cnt;
    frame(3, 24'hFF1234);
    check("bad_op_miso_oe", 32'(oe_cnt - snap_b), 32'd0);
    check("bad_op_strobes", 32'(strobe_cnt - snap_c), 32'd0);

    // Start and done in the same clk
    check("rv_before_clash", 32'(result_valid), 32'h1);
    same_clk_mode = 1'b1;
    exp_q.push_back('{kind: K_START, data: 8'h00});
    frame(1, 24'h030000);
    check("rv_start_wins", 32'(result_valid), 32'h0);

    check("miso_shift_on_fall_only", 32'(bad_shift), 32'd0);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
